rf_write_scheduler: RTL
=======================

# rf_write_scheduler

Arbitrates the single register-file write port among three writeback sources: the ALU, the load/store unit and the multi-cycle mul/div unit. Tracks outstanding destination registers in a 32-entry scoreboard so decode can stall on read-after-write and write-after-write hazards. Sits between the execute/memory stages and the 32x32 register file, which commits on the falling clock edge. All arbitration state and the write-port outputs update on the rising edge.

## Interface
- DATA_WIDTH, 32, writeback data width
- STARVE_LIMIT, 4, cycles a waiting requester may lose before it is promoted to top priority; legal range 1..15

- clk  in  1  clock; rising-edge logic
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  decode issues an instruction that writes rd
- issue_rd  in  5  destination of the issued instruction
- dec_rs1, dec_rs2, dec_rd  in  5 each  operands of the instruction currently in decode
- hazard  out  1  decode must stall: rs1, rs2 or rd is pending
- wb_valid[i]  in  1  writeback request; i = 0 ALU, 1 LSU, 2 MDU
- wb_rd[i]  in  5  destination register
- wb_data[i]  in  DATA_WIDTH  result
- wb_ready[i]  out  1  grant; the request is accepted in a cycle with valid && ready
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  DATA_WIDTH  register-file write data (registered)
- pending  out  32  scoreboard bit vector; bit 0 is always 0

## Operation
- Arbitration is combinational from wb_valid and the starve counters. At most one wb_ready is high per cycle.
- Base priority order: ALU, then LSU, then MDU.
- Each requester has a 4-bit starve counter:
  - It increments in every cycle its wb_valid is high and it is not granted.
  - It clears on grant, or when wb_valid is low.
  - It saturates at 15.
- A requester whose counter is at least STARVE_LIMIT is promoted above all non-promoted requesters.
- Among several promoted requesters, the one with the higher counter wins. Ties go to the lower index.
- A requester holds wb_valid, wb_rd and wb_data stable until it is accepted. A request with wb_rd = 0 is accepted normally, but produces rf_we = 0.
- On accept:
  - Next cycle rf_we = (wb_rd != 0), rf_waddr = wb_rd, rf_wdata = wb_data.
  - In the same rising edge, pending[wb_rd] clears.
- When no request is accepted, rf_we = 0 next cycle. rf_waddr and rf_wdata hold their previous values.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets pending[issue_rd] on the rising edge.
  - issue_rd = 0 is ignored.
- Simultaneous set and clear of the same register in one cycle: set wins. The write being retired is the older instruction; the newly issued one is still outstanding.
- hazard = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd]. It is combinational and uses the current registered scoreboard, with no bypass.
- The scheduler does not order writes to the same rd across sources. Decode's WAW stall (on dec_rd) guarantees at most one outstanding writer per register.

## Timing
- Reset (rst high at a rising edge):
  - pending = 0; all starve counters = 0.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - wb_ready and hazard are combinational and follow from the cleared state.
- rst asserted mid-operation discards in-flight grants. Requests accepted in the reset cycle are not written back.
- Grant-to-commit latency:
  - Accept at rising edge N drives rf_we/addr/data for cycle N..N+1.
  - The register file commits at the falling edge within that cycle.
  - The value is readable by decode from cycle N+1 onward.
- pending[rd] clears at edge N, together with the accept. hazard for a consumer therefore drops in the same cycle the write is presented, and the negedge commit makes the data valid for that cycle's decode read.
- Throughput: one write per cycle. Worst-case wait for a continuously valid requester is STARVE_LIMIT + 2 cycles.

## Test plan
- Reset then idle -> rf_we = 0, pending = 0, hazard = 0 for dec_rs1 = 5, dec_rs2 = 6, dec_rd = 7.
- issue rd = 5, then hold dec_rs1 = 5 -> hazard = 1. Next, LSU writes rd = 5, data 0xDEADBEEF -> wb_ready[1] = 1 that cycle; next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF, pending[5] = 0, hazard = 0.
- ALU and MDU valid every cycle, ALU presenting a new request each cycle, STARVE_LIMIT = 4 -> MDU is granted on its 5th valid cycle; ALU is granted the other 4 cycles; never two readies high together.
- Same-cycle issue rd = 9 and LSU writeback of rd = 9 -> write presented next cycle; pending[9] remains 1.
- ALU writeback rd = 0, data 0x1234 -> accepted (wb_ready[0] = 1); next cycle rf_we = 0; pending unchanged. issue_rd = 0 never sets pending[0].
- Three writebacks pending with rd = 1, 2, 3, then rst for one cycle -> pending = 0 and rf_we = 0 after the edge; none of the three is written.

Source files
------------

// File: rtl/rf_write_scheduler_if.sv
// rtl/rf_write_scheduler_if.sv - writeback request/grant bundle for the three writeback sources
interface rf_write_scheduler_if #(
    parameter int DATA_WIDTH = 32
);
    // index 0 = ALU, 1 = LSU, 2 = MDU
    logic [2:0]                 wb_valid;
    logic [2:0][4:0]            wb_rd;
    logic [2:0][DATA_WIDTH-1:0] wb_data;
    logic [2:0]                 wb_ready;

    modport master (
        output wb_valid,
        output wb_rd,
        output wb_data,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_rd,
        input  wb_data,
        output wb_ready
    );
endinterface

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - starvation-aware register-file write-port arbiter with hazard scoreboard
module rf_write_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    input  logic [4:0]            dec_rs1,
    input  logic [4:0]            dec_rs2,
    input  logic [4:0]            dec_rd,
    output logic                  hazard,
    rf_write_scheduler_if.slave   wb,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [31:0]           pending
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [2:0][3:0]       starve_cnt;
    logic [2:0]            promoted;
    logic [2:0]            grant;
    logic                  any_promoted;
    logic [1:0]            best_idx;
    logic [3:0]            best_cnt;
    logic                  accept;
    logic [4:0]            acc_rd;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [31:0]           pending_next;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            promoted[i] = wb.wb_valid[i] && (starve_cnt[i] >= LIMIT);
        end
    end

    // Promoted requesters outrank base order; strict '>' keeps ties at the lower index.
    always_comb begin
        grant        = '0;
        any_promoted = 1'b0;
        best_idx     = '0;
        best_cnt     = '0;
        for (int i = 0; i < 3; i++) begin
            if (promoted[i] && (!any_promoted || starve_cnt[i] > best_cnt)) begin
                any_promoted = 1'b1;
                best_idx     = 2'(i);
                best_cnt     = starve_cnt[i];
            end
        end
        if (any_promoted)          grant[best_idx] = 1'b1;
        else if (wb.wb_valid[0])   grant = 3'b001;
        else if (wb.wb_valid[1])   grant = 3'b010;
        else if (wb.wb_valid[2])   grant = 3'b100;
    end

    assign wb.wb_ready = grant;
    assign accept      = |grant;

    always_comb begin
        acc_rd   = '0;
        acc_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                acc_rd   = wb.wb_rd[i];
                acc_data = wb.wb_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!wb.wb_valid[i] || grant[i])
                    starve_cnt[i] <= '0;
                else if (starve_cnt[i] != 4'hF)
                    starve_cnt[i] <= starve_cnt[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (accept) begin
            rf_we    <= (acc_rd != 5'd0);
            rf_waddr <= acc_rd;
            rf_wdata <= acc_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Set is applied after clear: the newly issued writer is younger than the one retiring.
    always_comb begin
        pending_next = pending;
        if (accept && acc_rd != 5'd0)
            pending_next[acc_rd] = 1'b0;
        if (issue_valid && issue_rd != 5'd0)
            pending_next[issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_next;
    end

    assign hazard = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd];
endmodule
